// File: rtl/pc_trace_capture.sv
// pc_trace_capture
//   Capture stage in front of the instruction-trace printer. The core PC is
//   sampled every clock. Whenever it changes, an event {pc, timestamp,
//   lost-count} is pushed into a first-word-fall-through FIFO, which a
//   ready/valid consumer drains. An optional PC trigger stops capture POST
//   events after the trigger event. The arm pulse restarts capture.
//
// Ports
//   clk       system clock; all logic runs on the rising edge
//   rst       synchronous reset, active-high; also discards FIFO contents
//   pc_in     core program counter (PC_W bits)
//   pc_valid  pc_in is meaningful this cycle
//   cap_en    capture enable; gates pushes only
//   trig_en   trigger enable
//   trig_pc   trigger address
//   arm       pulse that restarts capture from the FROZEN state
//   ev_valid  a head event is available
//   ev_ready  consumer accepts the head event
//   ev_pc     head event PC
//   ev_ts     head event timestamp (cycle count)
//   ev_lost   events dropped just before the head event (saturates at 255)
//   level     FIFO occupancy
//   frozen    capture is frozen after a trigger sequence
module pc_trace_capture #(
    parameter int PC_W       = 12,
    parameter int TS_W       = 32,
    parameter int DEPTH_LOG2 = 4,
    parameter int POST       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PC_W-1:0]       pc_in,
    input  logic                  pc_valid,
    input  logic                  cap_en,
    input  logic                  trig_en,
    input  logic [PC_W-1:0]       trig_pc,
    input  logic                  arm,
    output logic                  ev_valid,
    input  logic                  ev_ready,
    output logic [PC_W-1:0]       ev_pc,
    output logic [TS_W-1:0]       ev_ts,
    output logic [7:0]            ev_lost,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  frozen
);

    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int EV_W   = PC_W + TS_W + 8;
    localparam int LVL_W  = DEPTH_LOG2 + 1;
    localparam int PCNT_W = (POST > 1) ? $clog2(POST) : 1;

    typedef enum logic [1:0] {
        ST_ARMED,
        ST_POST,
        ST_FROZEN
    } state_t;

    state_t                 state_reg, state_next;
    logic [PCNT_W-1:0]      post_cnt_reg, post_cnt_next;

    logic [TS_W-1:0]        ts_reg;
    logic [PC_W-1:0]        last_pc_reg;
    logic                   first_reg;
    logic [7:0]             lost_reg;

    logic [EV_W-1:0]        mem [DEPTH];
    logic [EV_W-1:0]        head_reg;
    logic [DEPTH_LOG2-1:0]  wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]       level_reg, level_next;

    logic                   chg, cap, pop, full, push, drop, bypass;
    logic                   trig_hit;
    logic [EV_W-1:0]        push_data;

    // ------------------------------------------------------------------
    // Capture decision
    // ------------------------------------------------------------------
    assign chg       = pc_valid & (first_reg | (pc_in != last_pc_reg));
    assign cap       = chg & cap_en & (state_reg != ST_FROZEN);
    assign pop       = (level_reg != '0) & ev_ready;
    // Occupancy reaches DEPTH only with the MSB set.
    assign full      = level_reg[DEPTH_LOG2];
    // A full FIFO still takes the event when the head leaves in the same cycle.
    assign push      = cap & (~full | pop);
    assign drop      = cap & ~push;
    assign push_data = {pc_in, ts_reg, lost_reg};
    assign trig_hit  = trig_en & (pc_in == trig_pc);

    // ------------------------------------------------------------------
    // FSM: it advances only on a capture, whether the event was accepted
    // or dropped.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        post_cnt_next = post_cnt_reg;
        unique case (state_reg)
            ST_ARMED: begin
                if (cap && trig_hit) begin
                    if (POST == 0) begin
                        state_next = ST_FROZEN;
                    end else begin
                        state_next    = ST_POST;
                        post_cnt_next = '0;
                    end
                end
            end
            ST_POST: begin
                if (cap) begin
                    if (post_cnt_reg == PCNT_W'(POST - 1)) begin
                        state_next = ST_FROZEN;
                    end else begin
                        post_cnt_next = post_cnt_reg + 1'b1;
                    end
                end
            end
            ST_FROZEN: begin
                if (arm) begin
                    state_next = ST_ARMED;
                end
            end
            default: begin
                state_next = ST_ARMED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_ARMED;
            post_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            post_cnt_reg <= post_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Timestamp, change tracking and lost counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_reg      <= '0;
            last_pc_reg <= '0;
            first_reg   <= 1'b1;
            lost_reg    <= '0;
        end else begin
            ts_reg <= ts_reg + 1'b1;
            if (pc_valid) begin
                last_pc_reg <= pc_in;
                first_reg   <= 1'b0;
            end
            // Re-arming forces the next valid PC to be captured, even when
            // it matches the last PC seen while frozen.
            if ((state_reg == ST_FROZEN) && arm) begin
                first_reg <= 1'b1;
            end
            if (push) begin
                lost_reg <= '0;
            end else if (drop && (lost_reg != 8'hFF)) begin
                lost_reg <= lost_reg + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FWFT FIFO: the storage array has a registered read into head_reg.
    // The read address is the head pointer after this cycle's pop. When the
    // FIFO would otherwise be empty, the incoming event goes straight into
    // head_reg.
    // ------------------------------------------------------------------
    assign rd_ptr_next = pop ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_comb begin
        level_next = level_reg;
        unique case ({push, pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // The new event becomes the head when nothing is left after the pop.
    assign bypass = push & ((level_reg == '0) | (pop & (level_reg == LVL_W'(1))));

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
        end else if (bypass) begin
            head_reg <= push_data;
        end else if (level_next != '0) begin
            // The write pointer never equals rd_ptr_next here, so the
            // read returns the old contents of that entry.
            head_reg <= mem[rd_ptr_next];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ev_valid                = (level_reg != '0);
    assign {ev_pc, ev_ts, ev_lost} = head_reg;
    assign level                   = level_reg;
    assign frozen                  = (state_reg == ST_FROZEN);

endmodule
